// File: rtl/nand_phy_pkg.sv
// Types and constants shared by the NV-DDR write sequencer and the read-side capture logic.
package nand_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_PST  = 2'd3
    } wr_state_e;

    localparam int DQ_WIDTH_DEF = 8;
    localparam int PRE_CYC_DEF  = 2;
    localparam int PST_CYC_DEF  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nand_phy_dq_wr_seq.sv
// NV-DDR write-burst sequencer: frames byte-pair bursts with DQS preamble/postamble for the DQ/DQS IOBs.
// Optional running XOR of sent bytes on wr_checksum when NAND_WR_CHECKSUM_EN is defined.
module nand_phy_dq_wr_seq
    import nand_phy_pkg::*;
#(
    parameter int DQ_WIDTH = DQ_WIDTH_DEF,
    parameter int LEN_W    = 16,
    parameter int PRE_CYC  = PRE_CYC_DEF,
    parameter int PST_CYC  = PST_CYC_DEF
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic [2*DQ_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DQ_WIDTH-1:0]   wr_data_rise,
    output logic [DQ_WIDTH-1:0]   wr_data_fall,
    output logic                  dq_oe_n,
    output logic                  dqs_oe_n,
    output logic                  dqs_en,
    output logic [DQ_WIDTH-1:0]   wr_checksum
);

    localparam int PH_W = $clog2(max_int(PRE_CYC, PST_CYC) + 1);
    localparam logic [PH_W-1:0] PRE_LOAD = PH_W'(PRE_CYC - 1);
    // PST is entered on the last accept, so one extra phase covers the cycle showing the last word.
    localparam logic [PH_W-1:0] PST_LOAD = PH_W'(PST_CYC);

    wr_state_e            state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 in_ready_q, in_ready_d;
    logic                 dq_oe_n_q, dq_oe_n_d;
    logic                 dqs_oe_n_q, dqs_oe_n_d;
    logic                 dqs_en_q, dqs_en_d;
    logic [DQ_WIDTH-1:0]  rise_q, rise_d;
    logic [DQ_WIDTH-1:0]  fall_q, fall_d;
    logic                 accept;
    logic                 start_ok;

    assign accept   = in_valid & in_ready_q;
    assign start_ok = start & (state_q == ST_IDLE);

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            dq_oe_n_q  <= 1'b1;
            dqs_oe_n_q <= 1'b1;
            dqs_en_q   <= 1'b0;
            rise_q     <= '0;
            fall_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            dq_oe_n_q  <= dq_oe_n_d;
            dqs_oe_n_q <= dqs_oe_n_d;
            dqs_en_q   <= dqs_en_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start_ok && burst_len != '0) begin
                    state_d = ST_PRE;
                    phase_d = PRE_LOAD;
                    cnt_d   = burst_len;
                end
            end
            ST_PRE: begin
                // in_ready is already up in the final preamble cycle, so a word may land here
                if (phase_q == '0) begin
                    if (accept && cnt_q == LEN_W'(1)) begin
                        state_d = ST_PST;
                        phase_d = PST_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_DATA: begin
                if (accept && cnt_q == LEN_W'(1)) begin
                    state_d = ST_PST;
                    phase_d = PST_LOAD;
                end
            end
            ST_PST: begin
                if (phase_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = ((state_q == ST_PST) && (phase_q == '0)) ||
                     (start_ok && (burst_len == '0));
        dq_oe_n_d  = (state_d == ST_IDLE);
        dqs_oe_n_d = (state_d == ST_IDLE);
        dqs_en_d   = accept;
        rise_d     = rise_q;
        fall_d     = fall_q;
        if (accept) begin
            rise_d = in_data[DQ_WIDTH-1:0];
            fall_d = in_data[2*DQ_WIDTH-1:DQ_WIDTH];
        end
        in_ready_d = (cnt_d != '0) &&
                     (((state_d == ST_PRE) && (phase_d == '0)) || (state_d == ST_DATA));
    end

`ifdef NAND_WR_CHECKSUM_EN
    logic [DQ_WIDTH-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (start_ok) begin
            chk_d = '0;
        end else if (accept) begin
            chk_d = chk_q ^ in_data[DQ_WIDTH-1:0] ^ in_data[2*DQ_WIDTH-1:DQ_WIDTH];
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign wr_checksum = chk_q;
`else
    assign wr_checksum = '0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign in_ready     = in_ready_q;
    assign wr_data_rise = rise_q;
    assign wr_data_fall = fall_q;
    assign dq_oe_n      = dq_oe_n_q;
    assign dqs_oe_n     = dqs_oe_n_q;
    assign dqs_en       = dqs_en_q;

endmodule

// File: tb/tb_nand_phy_dq_wr_seq.sv
// Scoreboard bench for nand_phy_dq_wr_seq; checksum expectations follow NAND_WR_CHECKSUM_EN.
module tb_nand_phy_dq_wr_seq;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        start = 1'b0;
    logic [15:0] burst_len = '0;
    logic        busy, done;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  wr_data_rise, wr_data_fall, wr_checksum;
    logic        dq_oe_n, dqs_oe_n, dqs_en;

    int checks = 0;
    int errors = 0;
    int dqs_cnt = 0, done_cnt = 0, oe_low_cnt = 0, pre_cnt = 0;
    bit seen_dqs = 0;
    logic [7:0] last_rise = '0, last_fall = '0;
    logic [15:0] exp_q[$];
    logic [15:0] stim[$];

    nand_phy_dq_wr_seq dut (
        .clk0(clk0), .rst0(rst0), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_data_rise(wr_data_rise), .wr_data_fall(wr_data_fall),
        .dq_oe_n(dq_oe_n), .dqs_oe_n(dqs_oe_n), .dqs_en(dqs_en), .wr_checksum(wr_checksum)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: pops expected words whenever the DUT strobes DQS, checks hold during pauses
    always @(negedge clk0) begin
        logic [15:0] w;
        if (rst0) begin
            last_rise = '0;
            last_fall = '0;
            seen_dqs  = 0;
        end else begin
            if (!dq_oe_n) begin
                oe_low_cnt++;
                if (!dqs_en && !seen_dqs) pre_cnt++;
            end else begin
                seen_dqs = 0;
            end
            if (done) done_cnt++;
            if (dqs_en) begin
                dqs_cnt++;
                seen_dqs = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h%h required=none", wr_data_fall, wr_data_rise);
                end else begin
                    w = exp_q.pop_front();
                    check("word_rise", 32'(wr_data_rise), 32'(w[7:0]));
                    check("word_fall", 32'(wr_data_fall), 32'(w[15:8]));
                    check("oe_on_dqs", 32'({dq_oe_n, dqs_oe_n}), 32'(0));
                end
                last_rise = wr_data_rise;
                last_fall = wr_data_fall;
            end else if (!dq_oe_n) begin
                check("hold_rise", 32'(wr_data_rise), 32'(last_rise));
                check("hold_fall", 32'(wr_data_fall), 32'(last_fall));
            end
        end
    end

    task automatic clear_counts();
        dqs_cnt = 0; done_cnt = 0; oe_low_cnt = 0; pre_cnt = 0;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(posedge clk0); #1;
        start = 1'b1;
        burst_len = len;
        @(posedge clk0); #1;
        start = 1'b0;
    endtask

    // drive n words of stim; after word index gap_after drop in_valid for gap cycles
    task automatic send(input int n, input int gap_after, input int gap);
        int i = 0;
        int cyc = 0;
        bit acc;
        in_valid = 1'b1;
        in_data  = stim[0];
        while (i < n && cyc < 200) begin
            @(negedge clk0);
            cyc++;
            acc = in_valid && in_ready;
            @(posedge clk0); #1;
            if (acc) begin
                exp_q.push_back(stim[i]);
                i++;
                in_data = (i < n) ? stim[i] : 16'hDEAD;
                if (i - 1 == gap_after && gap > 0 && i < n) begin
                    in_valid = 1'b0;
                    repeat (gap) @(posedge clk0);
                    #1 in_valid = 1'b1;
                end
            end
        end
        check("words_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_done();
        int c = 0;
        do begin
            @(negedge clk0);
            c++;
        end while (!done && c < 300);
        check("done_seen", 32'(done), 32'(1));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk0);
        check("rst_oe", 32'({dq_oe_n, dqs_oe_n}), 32'(3));
        check("rst_dqs_en", 32'(dqs_en), 32'(0));
        check("rst_data", 32'({wr_data_fall, wr_data_rise}), 32'(0));
        check("rst_flags", 32'({in_ready, busy, done}), 32'(0));
        check("rst_chk", 32'(wr_checksum), 32'(0));
        #2 rst0 = 1'b0;

        // 1: four words, in_valid held
        clear_counts();
        stim = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
        pulse_start(16'd4);
        @(negedge clk0);
        check("t1_busy", 32'(busy), 32'(1));
        check("t1_pre_oe", 32'({dq_oe_n, dqs_oe_n, dqs_en}), 32'(0));
        send(4, -1, 0);
        wait_done();
        in_valid = 1'b0;
        @(negedge clk0);
        check("t1_done_pulse", 32'(done), 32'(0));
        repeat (2) @(negedge clk0);
        #1;
        check("t1_dqs_cnt", 32'(dqs_cnt), 32'(4));
        check("t1_pre_cnt", 32'(pre_cnt), 32'(2));
        check("t1_oe_low", 32'(oe_low_cnt), 32'(8));
        check("t1_done_cnt", 32'(done_cnt), 32'(1));
        check("t1_oe_off", 32'({dq_oe_n, dqs_oe_n}), 32'(3));
        check("t1_idle", 32'(busy), 32'(0));

        // 2: three words with a two-cycle pause after the first
        clear_counts();
        stim = '{16'h2010, 16'h4030, 16'h6050};
        pulse_start(16'd3);
        send(3, 0, 2);
        @(negedge clk0);
        check("t2_ready_low", 32'(in_ready), 32'(0));
        wait_done();
        in_valid = 1'b0;
        repeat (3) @(negedge clk0);
        #1;
        check("t2_dqs_cnt", 32'(dqs_cnt), 32'(3));
        check("t2_oe_low", 32'(oe_low_cnt), 32'(9));
        check("t2_done_cnt", 32'(done_cnt), 32'(1));

        // 3: zero-length burst
        clear_counts();
        pulse_start(16'd0);
        @(negedge clk0);
        check("t3_done", 32'(done), 32'(1));
        check("t3_oe", 32'({dq_oe_n, dqs_oe_n}), 32'(3));
        @(negedge clk0);
        check("t3_done_once", 32'(done), 32'(0));
        repeat (3) @(negedge clk0);
        #1;
        check("t3_oe_low", 32'(oe_low_cnt), 32'(0));
        check("t3_done_cnt", 32'(done_cnt), 32'(1));

        // 4: reset in the middle of DATA
        clear_counts();
        stim = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
        pulse_start(16'd4);
        send(2, -1, 0);
        @(negedge clk0);
        check("t4_busy_mid", 32'(busy), 32'(1));
        #2 rst0 = 1'b1;
        #1;
        check("t4_rst_oe", 32'({dq_oe_n, dqs_oe_n}), 32'(3));
        check("t4_rst_data", 32'({wr_data_fall, wr_data_rise, dqs_en}), 32'(0));
        check("t4_rst_flags", 32'({in_ready, busy, done}), 32'(0));
        check("t4_rst_chk", 32'(wr_checksum), 32'(0));
        in_valid = 1'b0;
        @(negedge clk0);
        #2 rst0 = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk0);
        #1;
        check("t4_no_done", 32'(done_cnt), 32'(0));
        clear_counts();
        stim = '{16'h3344, 16'h5566};
        pulse_start(16'd2);
        send(2, -1, 0);
        wait_done();
        in_valid = 1'b0;
        repeat (3) @(negedge clk0);
        #1;
        check("t4_new_dqs", 32'(dqs_cnt), 32'(2));
        check("t4_new_done", 32'(done_cnt), 32'(1));

        // 5: start while busy ignored, back-to-back start in the done cycle
        clear_counts();
        stim = '{16'h9988, 16'hBBAA};
        pulse_start(16'd2);
        start = 1'b1;
        burst_len = 16'd5;
        @(posedge clk0); #1;
        start = 1'b0;
        send(2, -1, 0);
        wait_done();
        in_valid = 1'b0;
        start = 1'b1;
        burst_len = 16'd1;
        @(posedge clk0); #1;
        start = 1'b0;
        @(negedge clk0);
        check("t5_b2b_busy", 32'(busy), 32'(1));
        stim = '{16'hBEEF};
        send(1, -1, 0);
        wait_done();
        in_valid = 1'b0;
        repeat (3) @(negedge clk0);
        #1;
        check("t5_dqs_cnt", 32'(dqs_cnt), 32'(3));
        check("t5_done_cnt", 32'(done_cnt), 32'(2));
        check("t5_queue_empty", 32'(exp_q.size()), 32'(0));

        // 6: checksum
        stim = '{16'hA55A, 16'h0F0F};
        pulse_start(16'd2);
        send(2, -1, 0);
        wait_done();
        in_valid = 1'b0;
        repeat (3) @(negedge clk0);
`ifdef NAND_WR_CHECKSUM_EN
        check("t6_checksum", 32'(wr_checksum), 32'(8'hFF));
`else
        check("t6_checksum", 32'(wr_checksum), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
